// File: rtl/fp_sched_pkg.sv
// Purpose: shared defaults and width helpers for the FP adder scheduler.
// Contents:
//   DEF_*          default parameter values for fp_add_scheduler
//   ptr_width()    bits needed for a round-robin pointer over n requesters
//   cnt_width()    bits needed for an outstanding counter saturating at max_out
package fp_sched_pkg;

  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_PRECISION   = 32;
  localparam int unsigned DEF_ADD_LATENCY = 5;
  localparam int unsigned DEF_MAX_OUT     = 2;

  // Pointer width, never zero so single-requester builds still elaborate.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return (max_out > 0) ? $clog2(max_out + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin selector.
// Ports:
//   eligible  in   N_REQ  requesters allowed to win this cycle
//   rr_ptr    in   PTR_W  highest-priority index; search runs upward with wrap
//   grant     out  N_REQ  one-hot winner, all zero when nobody is eligible
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned PTR_W = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Walk from rr_ptr upward; the first eligible index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = PTR_W'((32'(rr_ptr) + off) % N_REQ);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Purpose: shares one pipelined FP adder among N_REQ requesters. Issues at
//   most one operation per cycle, chosen round-robin among requesters that
//   have a pending operation and fewer than MAX_OUT results outstanding, and
//   routes each returning result back to its owner via a one-hot tag pipe.
// Ports:
//   clk            in   1                single rising-edge clock
//   reset_n        in   1                synchronous reset, active HIGH
//   req_valid      in   N_REQ            per-requester operation pending
//   req_ready      out  N_REQ            one-hot grant (combinational)
//   req_a, req_b   in   N_REQ*PRECISION  packed operands, requester i at slice i
//   add_a_operand  out  PRECISION        registered operand A to the adder
//   add_b_operand  out  PRECISION        registered operand B to the adder
//   add_result     in   PRECISION        adder output, ADD_LATENCY edges later
//   resp_valid     out  N_REQ            one-hot owner of add_result this cycle
//   resp_data      out  PRECISION        add_result passed straight through
//   busy           out  1                any operation in flight
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = DEF_N_REQ,
  parameter int unsigned PRECISION   = DEF_PRECISION,
  parameter int unsigned ADD_LATENCY = DEF_ADD_LATENCY,
  parameter int unsigned MAX_OUT     = DEF_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*PRECISION-1:0] req_a,
  input  logic [N_REQ*PRECISION-1:0] req_b,
  output logic [PRECISION-1:0]       add_a_operand,
  output logic [PRECISION-1:0]       add_b_operand,
  input  logic [PRECISION-1:0]       add_result,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [PRECISION-1:0]       resp_data,
  output logic                       busy
);

  localparam int unsigned PTR_W     = ptr_width(N_REQ);
  localparam int unsigned CNT_W     = cnt_width(MAX_OUT);
  // One stage for the operand register plus the adder's own latency.
  localparam int unsigned TAG_DEPTH = 1 + ADD_LATENCY;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q [N_REQ];
  logic [CNT_W-1:0]     cnt_d [N_REQ];
  logic [N_REQ-1:0]     tag_q [TAG_DEPTH];
  logic [N_REQ-1:0]     tag_d [TAG_DEPTH];
  logic [PRECISION-1:0] opa_q, opa_d;
  logic [PRECISION-1:0] opb_q, opb_d;

  logic [N_REQ-1:0]     eligible_c;
  logic [N_REQ-1:0]     grant_c;
  logic [N_REQ-1:0]     hs_c;
  logic [N_REQ-1:0]     ret_c;
  logic                 busy_c;

  // Eligibility uses the registered count, so a requester at the limit
  // only reopens the cycle after its response has been retired.
  always_comb begin
    eligible_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible_c[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .eligible (eligible_c),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant_c)
  );

  // Grants are suppressed while reset is asserted so nothing can handshake.
  assign req_ready = reset_n ? '0 : grant_c;
  assign hs_c      = req_valid & req_ready;
  assign ret_c     = tag_q[TAG_DEPTH-1];

  // Next-state: pointer, operand capture, tag shift and outstanding counts.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    for (int unsigned s = 0; s < TAG_DEPTH; s++) begin
      tag_d[s] = tag_q[s];
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (hs_c[i]) begin
        rr_ptr_d = PTR_W'((i + 1) % N_REQ);
        opa_d    = req_a[i*PRECISION +: PRECISION];
        opb_d    = req_b[i*PRECISION +: PRECISION];
      end
    end

    tag_d[0] = hs_c;
    for (int unsigned s = 1; s < TAG_DEPTH; s++) begin
      tag_d[s] = tag_q[s-1];
    end

    // Issue and retire in the same cycle cancel out.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      unique case ({hs_c[i], ret_c[i]})
        2'b10: begin
          if (cnt_q[i] < CNT_W'(MAX_OUT)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rr_ptr_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      for (int unsigned s = 0; s < TAG_DEPTH; s++) begin
        tag_q[s] <= '0;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      for (int unsigned s = 0; s < TAG_DEPTH; s++) begin
        tag_q[s] <= tag_d[s];
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Any live tag stage means an operation is still in flight.
  always_comb begin
    busy_c = 1'b0;
    for (int unsigned s = 0; s < TAG_DEPTH; s++) begin
      busy_c = busy_c | (|tag_q[s]);
    end
  end

  assign add_a_operand = opa_q;
  assign add_b_operand = opb_q;
  assign resp_data     = add_result;
  assign resp_valid    = reset_n ? '0 : ret_c;
  assign busy          = reset_n ? 1'b0 : busy_c;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: directed vector table, a fixed 1.0+2.0 case and
// randomized traffic against a queue-based reference model. A behavioural
// FP adder with ADD_LATENCY stages is attached to the adder ports.
module tb_fp_add_scheduler;

  localparam int N   = 4;
  localparam int P   = 32;
  localparam int LAT = 5;
  localparam int MX  = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*P-1:0] req_a;
  logic [N*P-1:0] req_b;
  logic [P-1:0]   add_a_operand;
  logic [P-1:0]   add_b_operand;
  logic [P-1:0]   add_result;
  logic [N-1:0]   resp_valid;
  logic [P-1:0]   resp_data;
  logic           busy;

  fp_add_scheduler #(
    .N_REQ(N), .PRECISION(P), .ADD_LATENCY(LAT), .MAX_OUT(MX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a_operand(add_a_operand),
    .add_b_operand(add_b_operand), .add_result(add_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural FP32 helpers (normal values only) ----------
  function automatic real fp32_to_real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'({24'd0, x[30:23]}) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp32(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
  endfunction

  function automatic logic [31:0] rand_fp();
    return real_to_fp32(real'(int'($urandom_range(0, 2000)) - 1000));
  endfunction

  // Attached adder: result visible LAT edges after operands are presented.
  logic [31:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fp_add(add_a_operand, add_b_operand);
    for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_result = add_pipe[LAT-1];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          idx;
    logic [31:0] data;
  } pend_t;

  pend_t       m_q[$];
  int          m_cnt [N];
  int          m_rr;
  int          m_cyc;
  logic [31:0] m_opa, m_opb;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr  = 0;
    m_opa = 32'd0;
    m_opb = 32'd0;
  endtask

  // Called once per cycle after inputs settle; checks outputs then advances.
  task automatic model_step();
    int          g;
    int          ri;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_resp;
    check("opa", add_a_operand, m_opa);
    check("opb", add_b_operand, m_opb);
    if (reset_n) begin
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst resp", 32'(resp_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      model_reset();
      m_cyc++;
      return;
    end
    g = -1;
    for (int off = 0; off < N; off++) begin
      ri = (m_rr + off) % N;
      if (g < 0 && req_valid[ri] && m_cnt[ri] < MX) g = ri;
    end
    exp_ready = (g < 0) ? 4'd0 : 4'(1 << g);
    check("m ready", 32'(req_ready), 32'(exp_ready));
    exp_resp = 4'd0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) exp_resp = 4'(1 << m_q[0].idx);
    check("m resp", 32'(resp_valid), 32'(exp_resp));
    if (exp_resp != 4'd0) check("m data", resp_data, m_q[0].data);
    check("m busy", 32'(busy), 32'(m_q.size() != 0));
    if (exp_resp != 4'd0) begin
      m_cnt[m_q[0].idx]--;
      void'(m_q.pop_front());
    end
    if (g >= 0) begin
      m_opa = req_a[g*P +: P];
      m_opb = req_b[g*P +: P];
      m_q.push_back('{due: m_cyc + 1 + LAT, idx: g, data: fp_add(m_opa, m_opb)});
      m_cnt[g]++;
      m_rr = (g + 1) % N;
    end
    m_cyc++;
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic run_cycle(input logic rst, input logic [3:0] v, input logic fixed);
    @(posedge clk);
    #1;
    reset_n   = rst;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*P +: P] = fixed ? 32'h3F80_0000 : rand_fp();
      req_b[i*P +: P] = fixed ? 32'h4000_0000 : rand_fp();
    end
    @(negedge clk);
    model_step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] resp;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_row(input logic rst, input logic [3:0] valid,
                                  input logic [3:0] ready, input logic [3:0] resp,
                                  input logic bsy);
    tbl.push_back('{rst: rst, valid: valid, ready: ready, resp: resp, busy: bsy});
  endfunction

  function automatic logic [3:0] oh(input int n);
    return 4'(1 << n);
  endfunction

  initial begin
    // All four requesters from cycle 0: grants 0,1,2,3,0,1; responses from cycle 6.
    add_row(1'b1, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c <= 12; c++)
      add_row(1'b0, (c <= 5) ? 4'hF : 4'h0, (c <= 5) ? oh(c % 4) : 4'h0,
              (c >= 6 && c <= 11) ? oh((c - 6) % 4) : 4'h0, c >= 1 && c <= 11);
    // Requester 2 alone: blocked at MAX_OUT in cycles 2-6, regrant at 7.
    add_row(1'b1, 4'h4, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c <= 14; c++)
      add_row(1'b0, (c <= 7) ? 4'h4 : 4'h0, (c == 0 || c == 1 || c == 7) ? 4'h4 : 4'h0,
              (c == 6 || c == 7 || c == 13) ? 4'h4 : 4'h0, c >= 1 && c <= 13);
    // Pointer at 2 with requesters 1 and 3 pending: 3 wins, then 1.
    add_row(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c <= 9; c++)
      add_row(1'b0, (c == 0) ? 4'h2 : (c <= 2) ? 4'hA : 4'h0,
              (c == 0 || c == 2) ? 4'h2 : (c == 1) ? 4'h8 : 4'h0,
              (c == 6 || c == 8) ? 4'h2 : (c == 7) ? 4'h8 : 4'h0, c >= 1 && c <= 8);
    // Reset with three in flight: stale results never flagged, restart at 0.
    add_row(1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c <= 2; c++) add_row(1'b0, 4'hF, oh(c), 4'h0, c >= 1);
    add_row(1'b1, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c <= 7; c++)
      add_row(1'b0, (c == 0) ? 4'hF : 4'h0, (c == 0) ? 4'h1 : 4'h0,
              (c == 6) ? 4'h1 : 4'h0, c >= 1 && c <= 6);

    reset_n   = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    m_cyc     = 0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int r = 0; r < tbl.size(); r++) begin
      run_cycle(tbl[r].rst, tbl[r].valid, 1'b0);
      check($sformatf("row%0d ready", r), 32'(req_ready), 32'(tbl[r].ready));
      check($sformatf("row%0d resp", r), 32'(resp_valid), 32'(tbl[r].resp));
      check($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].busy));
    end

    // 1.0 + 2.0 from requester 0 through the attached adder.
    run_cycle(1'b1, 4'h0, 1'b0);
    run_cycle(1'b0, 4'h1, 1'b1);
    check("add ready", 32'(req_ready), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      run_cycle(1'b0, 4'h0, 1'b0);
      if (k < 6) check($sformatf("add early%0d", k), 32'(resp_valid), 32'h0);
    end
    check("add resp", 32'(resp_valid), 32'h1);
    check("add data", resp_data, 32'h4040_0000);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 1500; c++) begin
      run_cycle($urandom_range(0, 99) == 0, 4'($urandom), 1'b0);
    end
    // Drain.
    for (int c = 0; c < 10; c++) run_cycle(1'b0, 4'h0, 1'b0);
    check("drain busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_scheduler.md
FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one pipelined FP adder.
REQ-002 The block SHALL have parameter PRECISION, default 32, giving the IEEE-754 word width.
REQ-003 The block SHALL have parameter ADD_LATENCY, default 5, giving the clock edges from operands presented at the adder inputs to the result at the adder output.
REQ-004 The block SHALL have parameter MAX_OUT, default 2, giving the maximum in-flight operations per requester.
REQ-005 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n  input  1  synchronous, active-high reset (1 = reset asserted).
REQ-007 The block SHALL have port req_valid  input  N_REQ  one bit per requester, operation pending.
REQ-008 The block SHALL have port req_ready  output  N_REQ  one-hot grant; at most one bit high.
REQ-009 The block SHALL have port req_a  input  N_REQ*PRECISION  packed operand A, requester i at slice i.
REQ-010 The block SHALL have port req_b  input  N_REQ*PRECISION  packed operand B, requester i at slice i.
REQ-011 The block SHALL have port add_a_operand  output  PRECISION  registered operand A to the adder.
REQ-012 The block SHALL have port add_b_operand  output  PRECISION  registered operand B to the adder.
REQ-013 The block SHALL have port add_result  input  PRECISION  the adder result.
REQ-014 The block SHALL have port resp_valid  output  N_REQ  one-hot; the result belongs to requester i.
REQ-015 The block SHALL have port resp_data  output  PRECISION  add_result passed through combinationally.
REQ-016 The block SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-017 Requester i SHALL be eligible when req_valid[i]=1 and its registered outstanding count is below MAX_OUT.
REQ-018 Arbitration SHALL be round-robin, searching from pointer rr_ptr upward with wrap-around; req_ready SHALL be combinational from eligibility and rr_ptr.
REQ-019 A handshake SHALL be req_valid[i]&req_ready[i]; on it, rr_ptr SHALL become (i+1) mod N_REQ. rr_ptr SHALL hold when there is no grant.
REQ-020 On a handshake, add_a_operand and add_b_operand SHALL load that requester's slices at the same edge; with no handshake they SHALL hold their values.
REQ-021 A tag pipeline of depth 1+ADD_LATENCY SHALL carry the one-hot grant; its last stage SHALL drive resp_valid.
REQ-022 A handshake in cycle k SHALL produce resp_valid in cycle k+1+ADD_LATENCY (k+6 by default); throughput SHALL be one issue per cycle.
REQ-023 The outstanding count of requester i SHALL increment on its grant and decrement on its resp_valid; when both occur in the same cycle it SHALL be unchanged.
REQ-024 The count SHALL never exceed MAX_OUT or go below 0. A requester at MAX_OUT SHALL stay ineligible during the cycle its response returns and SHALL become eligible the next cycle.
REQ-025 busy SHALL equal the OR of all tag-pipeline stages.

Reset
REQ-026 While reset_n=1 at an edge, the block SHALL clear rr_ptr to 0, all counts to 0, and all tag stages to 0; add_a_operand and add_b_operand SHALL be 0.
REQ-027 During reset, req_ready, resp_valid and busy SHALL be 0.
REQ-028 Reset mid-operation SHALL discard in-flight operations: results emerging from the adder afterwards SHALL never assert resp_valid.

Structure
REQ-029 Package fp_sched_pkg SHALL hold the default N_REQ, PRECISION, ADD_LATENCY and MAX_OUT constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs eligible and rr_ptr; output one-hot grant).

Verification
REQ-031 Requester 0 sends a=0x3F800000, b=0x40000000 with a real adder attached -> resp_valid=0001 six cycles later and resp_data=0x40400000.
REQ-032 All four requesters hold req_valid from cycle 0 -> grants in order 0,1,2,3,0,1 on consecutive cycles, and responses arrive in the same order starting at cycle 6.
REQ-033 Only requester 2 is valid continuously with MAX_OUT=2 -> grants at cycles 0 and 1, none in cycles 2-6, and a new grant at cycle 7.
REQ-034 Requesters 1 and 3 are both valid with rr_ptr=2 -> requester 3 is granted first, then 1.
REQ-035 Reset is asserted at cycle 3 with 3 operations in flight -> no resp_valid afterwards, busy=0, all counts 0, and the first grant after reset goes to requester 0.
